// File: rtl/smg_scan_module.sv
// smg_scan_module: time-multiplexed driver for a 4-digit 7-segment LED module.
// Each digit is lit for T1MS+1 clocks. The packed-BCD input is snapshotted once
// per 4-digit frame, so a frame never mixes old and new digits.
// Ports:
//   CLK        system clock
//   RSTn       asynchronous active-low reset
//   Number_Sig packed BCD, [3:0] is digit 0 (rightmost)
//   Blank_En   leading-zero blanking enable, sampled at each digit tick
//   Dp_Sig     per-digit decimal point, present only with SMG_DP_EN defined
//   SMG_Data   segments {dp,g,f,e,d,c,b,a}, polarity from SEG_ACTIVE_LOW
//   Scan_Sig   digit selects, bit k = digit k, polarity from DIG_ACTIVE_LOW
//   Frame_Tick one-clock pulse on the edge that takes a new snapshot
// Optional feature macro: SMG_DP_EN (adds Dp_Sig and drives dp from it).
module smg_scan_module #(
    parameter logic [15:0] T1MS           = 16'd49_999,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [15:0] Number_Sig,
    input  logic        Blank_En,
`ifdef SMG_DP_EN
    input  logic [3:0]  Dp_Sig,
`endif
    output logic [7:0]  SMG_Data,
    output logic [3:0]  Scan_Sig,
    output logic        Frame_Tick
);
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [15:0] c1;
    logic [1:0]  idx;
    logic [15:0] snap;
    logic        tick;
    logic        frame_start;
    logic [1:0]  nxt_idx;
    logic [15:0] src;
    logic [3:0]  nib;
    logic        z1, z2, z3;
    logic        blank;
    logic        dp_bit;
    logic [7:0]  seg_hi;
    logic [3:0]  sel;
`ifdef SMG_DP_EN
    logic [3:0]  dp_snap;
    logic [3:0]  dp_src;
`endif

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h3F;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5B;
            4'd3:    dec7 = 7'h4F;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6D;
            4'd6:    dec7 = 7'h7D;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7F;
            4'd9:    dec7 = 7'h6F;
            default: dec7 = 7'h40;
        endcase
    endfunction

    always_comb begin
        tick        = (c1 == T1MS);
        frame_start = tick && (idx == 2'd3);
        nxt_idx     = idx + 2'd1;
        // at frame start digit 0 is decoded from the value being captured now
        src         = frame_start ? Number_Sig : snap;
        nib         = src[{nxt_idx, 2'b00} +: 4];
        z3          = (src[15:12] == 4'd0);
        z2          = z3 && (src[11:8] == 4'd0);
        z1          = z2 && (src[7:4] == 4'd0);
        blank       = Blank_En && ((nxt_idx == 2'd3) ? z3 :
                                   (nxt_idx == 2'd2) ? z2 :
                                   (nxt_idx == 2'd1) ? z1 : 1'b0);
`ifdef SMG_DP_EN
        dp_src      = frame_start ? Dp_Sig : dp_snap;
        dp_bit      = dp_src[nxt_idx];
`else
        dp_bit      = 1'b0;
`endif
        seg_hi      = {dp_bit, blank ? 7'h00 : dec7(nib)};
        sel         = 4'b0001 << nxt_idx;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            c1         <= 16'd0;
            idx        <= 2'd3;
            snap       <= 16'h0000;
            Frame_Tick <= 1'b0;
            SMG_Data   <= SEG_OFF;
            Scan_Sig   <= DIG_OFF;
`ifdef SMG_DP_EN
            dp_snap    <= 4'h0;
`endif
        end else begin
            c1         <= tick ? 16'd0 : c1 + 16'd1;
            Frame_Tick <= frame_start;
            if (tick) begin
                idx      <= nxt_idx;
                SMG_Data <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
                Scan_Sig <= DIG_ACTIVE_LOW ? ~sel : sel;
            end
            if (frame_start) begin
                snap    <= Number_Sig;
`ifdef SMG_DP_EN
                dp_snap <= Dp_Sig;
`endif
            end
        end
    end
endmodule

// File: tb/tb_smg_scan_module.sv
// tb_smg_scan_module: directed self-checking bench for smg_scan_module (T1MS=9).
// Ports: none (top-level bench). Honours SMG_DP_EN to exercise the dp feature.
module tb_smg_scan_module;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [15:0] Number_Sig = 16'h0000;
    logic        Blank_En = 1'b0;
    logic [7:0]  SMG_Data;
    logic [3:0]  Scan_Sig;
    logic        Frame_Tick;
    int          checks = 0;
    int          failures = 0;
`ifdef SMG_DP_EN
    logic [3:0]  Dp_Sig = 4'h0;
`endif

    smg_scan_module #(.T1MS(16'd9), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .Number_Sig(Number_Sig),
        .Blank_En(Blank_En),
`ifdef SMG_DP_EN
        .Dp_Sig(Dp_Sig),
`endif
        .SMG_Data(SMG_Data),
        .Scan_Sig(Scan_Sig),
        .Frame_Tick(Frame_Tick)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic restart();
        RSTn = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic test_reset();
        Number_Sig = 16'h1234;
        Blank_En = 1'b0;
        restart();
        step(25);
        RSTn = 1'b0;
        #1;
        checks++;
        if (SMG_Data !== 8'hFF) begin failures++; $display("FAIL rst_seg: got %h expected ff", SMG_Data); end
        checks++;
        if (Scan_Sig !== 4'hF) begin failures++; $display("FAIL rst_scan: got %b expected 1111", Scan_Sig); end
        checks++;
        if (Frame_Tick !== 1'b0) begin failures++; $display("FAIL rst_tick: got %b expected 0", Frame_Tick); end
        @(negedge CLK);
        RSTn = 1'b1;
        step(9);
        checks++;
        if (SMG_Data !== 8'hFF || Scan_Sig !== 4'hF || Frame_Tick !== 1'b0) begin
            failures++;
            $display("FAIL dark_period: got seg=%h scan=%b tick=%b expected ff 1111 0", SMG_Data, Scan_Sig, Frame_Tick);
        end
        step(1);
        checks++;
        if (Scan_Sig !== 4'b1110 || Frame_Tick !== 1'b1 || SMG_Data !== ~8'h66) begin
            failures++;
            $display("FAIL first_tick: got seg=%h scan=%b tick=%b expected 99 1110 1", SMG_Data, Scan_Sig, Frame_Tick);
        end
        step(1);
        checks++;
        if (Frame_Tick !== 1'b0 || Scan_Sig !== 4'b1110) begin
            failures++;
            $display("FAIL tick_pulse: got tick=%b scan=%b expected 0 1110", Frame_Tick, Scan_Sig);
        end
    endtask

    task automatic test_scan();
        logic [7:0] exp_seg [4];
        logic [3:0] exp_scan;
        exp_seg = '{~8'h66, ~8'h4F, ~8'h5B, ~8'h06};
        Number_Sig = 16'h1234;
        Blank_En = 1'b0;
        restart();
        step(10);
        for (int k = 0; k < 4; k++) begin
            exp_scan = ~(4'b0001 << k);
            checks++;
            if (Scan_Sig !== exp_scan || SMG_Data !== exp_seg[k] || Frame_Tick !== (k == 0)) begin
                failures++;
                $display("FAIL scan_d%0d: got seg=%h scan=%b tick=%b expected %h %b %b",
                         k, SMG_Data, Scan_Sig, Frame_Tick, exp_seg[k], exp_scan, k == 0);
            end
            step(10);
        end
        checks++;
        if (Frame_Tick !== 1'b1 || Scan_Sig !== 4'b1110) begin
            failures++;
            $display("FAIL frame_period: got tick=%b scan=%b expected 1 1110", Frame_Tick, Scan_Sig);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] exp_seg [7];
        exp_seg = '{~8'h4F, ~8'h5B, ~8'h06, ~8'h7F, ~8'h07, ~8'h7D, ~8'h6D};
        Number_Sig = 16'h1234;
        Blank_En = 1'b0;
        restart();
        step(20);
        Number_Sig = 16'h5678;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (SMG_Data !== exp_seg[i]) begin
                failures++;
                $display("FAIL snapshot_%0d: got seg=%h expected %h", i, SMG_Data, exp_seg[i]);
            end
            step(10);
        end
    endtask

    task automatic test_blank();
        logic [15:0] num [6];
        logic        ben [6];
        logic [7:0]  exp_seg [6][4];
        num = '{16'h0070, 16'h0000, 16'h1000, 16'h0070, 16'h0105, 16'h00A0};
        ben = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_seg = '{'{~8'h3F, ~8'h07, 8'hFF, 8'hFF},
                    '{~8'h3F, 8'hFF, 8'hFF, 8'hFF},
                    '{~8'h3F, ~8'h3F, ~8'h3F, ~8'h06},
                    '{~8'h3F, ~8'h07, ~8'h3F, ~8'h3F},
                    '{~8'h6D, ~8'h3F, ~8'h06, 8'hFF},
                    '{~8'h3F, ~8'h40, 8'hFF, 8'hFF}};
        for (int c = 0; c < 6; c++) begin
            Number_Sig = num[c];
            Blank_En = ben[c];
            if (c == 0) restart();
            step(10);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (SMG_Data !== exp_seg[c][k] || Scan_Sig !== ~(4'b0001 << k)) begin
                    failures++;
                    $display("FAIL blank_c%0d_d%0d: got seg=%h scan=%b expected %h %b",
                             c, k, SMG_Data, Scan_Sig, exp_seg[c][k], ~(4'b0001 << k));
                end
                if (k < 3) step(10);
            end
        end
    endtask

`ifdef SMG_DP_EN
    task automatic test_dp();
        logic [3:0] dps [2];
        logic       ben [2];
        logic [7:0] exp_seg [2][4];
        dps = '{4'b0010, 4'b1000};
        ben = '{1'b0, 1'b1};
        exp_seg = '{'{~8'h4F, ~8'hDB, ~8'h06, ~8'h3F},
                    '{~8'h4F, ~8'h5B, ~8'h06, 8'h7F}};
        Number_Sig = 16'h0123;
        for (int c = 0; c < 2; c++) begin
            Dp_Sig = dps[c];
            Blank_En = ben[c];
            if (c == 0) restart();
            step(10);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (SMG_Data !== exp_seg[c][k]) begin
                    failures++;
                    $display("FAIL dp_c%0d_d%0d: got seg=%h expected %h", c, k, SMG_Data, exp_seg[c][k]);
                end
                if (k < 3) step(10);
            end
        end
        Dp_Sig = 4'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_blank();
`ifdef SMG_DP_EN
        test_dp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
